// File: rtl/mips_pkg.sv
// Shared types for the mips memory path: arbiter FSM states and requester ids.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mips_pkg;

   localparam int unsigned MIPS_XLEN = 32;

   typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_DONE} arb_state_t;
   typedef enum logic [1:0] {REQ_FETCH, REQ_DATA, REQ_LOAD} arb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick between fetch (a) and data (b) with a priority pointer.
// Latency: grant is combinational; the pointer updates on the edge that takes the grant.
// Backpressure: a grant is only consumed when advance_i is high, otherwise the pointer holds.
module rr_arbiter2 (
   input  logic clk,
   input  logic reset,
   input  logic req_a_i,
   input  logic req_b_i,
   input  logic advance_i,
   output logic gnt_a_o,
   output logic gnt_b_o
);

   // ptr_q = 0 gives side a priority, 1 gives side b priority
   logic ptr_q, ptr_d;

   // Grant the favoured side when it asks, otherwise whichever side is asking
   always_comb begin
      gnt_a_o = req_a_i & (~ptr_q | ~req_b_i);
      gnt_b_o = req_b_i & ( ptr_q | ~req_a_i);
      ptr_d   = ptr_q;
      if (advance_i) begin
         if (gnt_a_o) begin
            ptr_d = 1'b1;
         end else if (gnt_b_o) begin
            ptr_d = 1'b0;
         end
      end
   end

   // Pointer register; after reset fetch is favoured
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one single-port memory between fetch, data and loader with a watchdog on mem_ack.
// Latency: mem_req rises the edge a request is taken; done pulses the cycle after ack or abort.
// Backpressure: requesters hold req until their done; one access in flight, 3 cycles minimum.
module mips_mem_arbiter
   import mips_pkg::*;
#(
   parameter int unsigned           TIMEOUT_CYCLES = 64,
   parameter logic [MIPS_XLEN-1:0]  ABORT_DATA     = 32'hDEADBEEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_req,
   input  logic [MIPS_XLEN-1:0]  i_addr,
   output logic [MIPS_XLEN-1:0]  i_rdata,
   output logic                  i_done,
   input  logic                  d_req,
   input  logic                  d_rd_wr,
   input  logic [MIPS_XLEN-1:0]  d_addr,
   input  logic [MIPS_XLEN-1:0]  d_wdata,
   output logic [MIPS_XLEN-1:0]  d_rdata,
   output logic                  d_done,
   input  logic                  l_req,
   input  logic [MIPS_XLEN-1:0]  l_addr,
   input  logic [MIPS_XLEN-1:0]  l_wdata,
   output logic                  l_done,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [MIPS_XLEN-1:0]  mem_addr,
   output logic [MIPS_XLEN-1:0]  mem_wdata,
   input  logic [MIPS_XLEN-1:0]  mem_rdata,
   input  logic                  mem_ack,
   output logic                  timeout_err
);

   localparam int unsigned    CNT_W     = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   arb_state_t              state_q, state_d;
   arb_req_t                win_q, win_d;
   logic [MIPS_XLEN-1:0]    addr_q, addr_d;
   logic                    we_q, we_d;
   logic [MIPS_XLEN-1:0]    wdata_q, wdata_d;
   logic [CNT_W-1:0]        wdog_q, wdog_d;
   logic [MIPS_XLEN-1:0]    i_rdata_q, i_rdata_d;
   logic [MIPS_XLEN-1:0]    d_rdata_q, d_rdata_d;
   logic                    i_done_q, i_done_d;
   logic                    d_done_q, d_done_d;
   logic                    l_done_q, l_done_d;
   logic                    terr_q, terr_d;

   logic                    gnt_f, gnt_d;
   logic                    rr_adv;
   logic                    finish;
   logic [MIPS_XLEN-1:0]    finish_data;

   rr_arbiter2 u_rr (
      .clk       (clk),
      .reset     (reset),
      .req_a_i   (i_req),
      .req_b_i   (d_req),
      .advance_i (rr_adv),
      .gnt_a_o   (gnt_f),
      .gnt_b_o   (gnt_d)
   );

   // Next-state logic: pick a winner in IDLE, watch ack/watchdog in ACCESS, pulse done in DONE
   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      wdog_d      = wdog_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      i_done_d    = 1'b0;
      d_done_d    = 1'b0;
      l_done_d    = 1'b0;
      terr_d      = terr_q;
      rr_adv      = 1'b0;
      finish      = 1'b0;
      finish_data = mem_rdata;

      case (state_q)
         ARB_IDLE: begin
            if (l_req) begin
               win_d   = REQ_LOAD;
               addr_d  = l_addr;
               we_d    = 1'b1;
               wdata_d = l_wdata;
               wdog_d  = '0;
               state_d = ARB_ACCESS;
            end else if (gnt_f) begin
               win_d   = REQ_FETCH;
               addr_d  = i_addr;
               we_d    = 1'b0;
               wdata_d = '0;
               wdog_d  = '0;
               rr_adv  = 1'b1;
               state_d = ARB_ACCESS;
            end else if (gnt_d) begin
               win_d   = REQ_DATA;
               addr_d  = d_addr;
               we_d    = ~d_rd_wr;
               wdata_d = d_wdata;
               wdog_d  = '0;
               rr_adv  = 1'b1;
               state_d = ARB_ACCESS;
            end
         end
         ARB_ACCESS: begin
            // ack takes precedence over a watchdog expiring in the same cycle
            if (mem_ack) begin
               finish = 1'b1;
            end else if (wdog_q == WDOG_LAST) begin
               finish      = 1'b1;
               finish_data = ABORT_DATA;
               terr_d      = 1'b1;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         ARB_DONE: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase

      if (finish) begin
         state_d = ARB_DONE;
         case (win_q)
            REQ_FETCH: begin
               i_rdata_d = finish_data;
               i_done_d  = 1'b1;
            end
            REQ_DATA: begin
               if (!we_q) begin
                  d_rdata_d = finish_data;
               end
               d_done_d = 1'b1;
            end
            default: begin
               l_done_d = 1'b1;
            end
         endcase
      end
   end

   // State and datapath registers; reset drops any in-flight access without a done
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ARB_IDLE;
         win_q     <= REQ_FETCH;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         wdog_q    <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         i_done_q  <= 1'b0;
         d_done_q  <= 1'b0;
         l_done_q  <= 1'b0;
         terr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         win_q     <= win_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         wdog_q    <= wdog_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         i_done_q  <= i_done_d;
         d_done_q  <= d_done_d;
         l_done_q  <= l_done_d;
         terr_q    <= terr_d;
      end
   end

   assign mem_req     = (state_q == ARB_ACCESS);
   assign mem_we      = we_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign i_rdata     = i_rdata_q;
   assign d_rdata     = d_rdata_q;
   assign i_done      = i_done_q;
   assign d_done      = d_done_q;
   assign l_done      = l_done_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a memory responder and access/done scoreboards.
// Latency: checks exact mem_req/done timing on the single-fetch and watchdog cases.
// Backpressure: requesters hold req until their own done, as the core does.
module tb_mips_mem_arbiter;

   typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } acc_t;
   typedef struct { logic [2:0] who; logic [31:0] rdata; bit chk; } dn_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_req = 1'b0, d_req = 1'b0, l_req = 1'b0, d_rd_wr = 1'b1;
   logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, l_addr = '0, l_wdata = '0;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        i_done, d_done, l_done, mem_req, mem_we, timeout_err;
   logic        mem_ack = 1'b0;

   int total = 0;
   int bad = 0;

   acc_t exp_acc[$];
   dn_t  exp_done[$];
   logic [31:0] mem[logic [31:0]];
   logic [31:0] shadow[logic [31:0]];

   int ack_delay = 1;   // ack on the Nth cycle of mem_req; 0 = never
   int req_cycles = 0;
   bit stray_ack = 1'b0;
   logic req_prev = 1'b0;

   mips_mem_arbiter #(.TIMEOUT_CYCLES(8), .ABORT_DATA(32'hDEADBEEF)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
      .d_req(d_req), .d_rd_wr(d_rd_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done),
      .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_done(l_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return a ^ 32'h1234_5678;
   endfunction

   function automatic logic [31:0] expect_word(input logic [31:0] a);
      return shadow.exists(a) ? shadow[a] : dflt(a);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_fetch(input logic [31:0] a);
      exp_acc.push_back('{1'b0, a, 32'h0});
      exp_done.push_back('{3'b001, expect_word(a), 1'b1});
   endtask

   task automatic exp_dread(input logic [31:0] a);
      exp_acc.push_back('{1'b0, a, 32'h0});
      exp_done.push_back('{3'b010, expect_word(a), 1'b1});
   endtask

   task automatic exp_dwrite(input logic [31:0] a, input logic [31:0] w);
      exp_acc.push_back('{1'b1, a, w});
      shadow[a] = w;
      exp_done.push_back('{3'b010, 32'h0, 1'b0});
   endtask

   task automatic exp_load(input logic [31:0] a, input logic [31:0] w);
      exp_acc.push_back('{1'b1, a, w});
      shadow[a] = w;
      exp_done.push_back('{3'b100, 32'h0, 1'b0});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      i_req = 1'b0; d_req = 1'b0; l_req = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   // Wait for one done pulse, counting mem_req cycles before it, then release all requests
   task automatic wait_one(input string tag, output int hi);
      int cyc;
      bit seen;
      hi = 0; cyc = 0; seen = 1'b0;
      while (!seen && cyc < 64) begin
         step();
         cyc++;
         if (i_done || d_done || l_done) seen = 1'b1;
         else if (mem_req) hi++;
      end
      i_req = 1'b0; d_req = 1'b0; l_req = 1'b0;
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
   endtask

   function automatic logic [31:0] dk_addr(input int k);
      return 32'h1000 + 32'(4 * (k / 2));
   endfunction

   // Memory model: ack after ack_delay cycles of mem_req, apply writes, return reads
   always @(posedge clk) begin
      #2;
      mem_ack = 1'b0;
      if (mem_req === 1'b1 && reset === 1'b0) begin
         req_cycles++;
         if (req_cycles == ack_delay) begin
            mem_ack = 1'b1;
            if (mem_we) mem[mem_addr] = mem_wdata;
            else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : dflt(mem_addr);
         end
      end else begin
         req_cycles = 0;
      end
      if (stray_ack) mem_ack = 1'b1;
   end

   // Access scoreboard: every new memory request must match the next expected grant
   always @(negedge clk) begin
      acc_t e;
      if (mem_req === 1'b1 && req_prev !== 1'b1) begin
         if (exp_acc.size() == 0) begin
            chk("unexpected_access_addr", mem_addr, 32'hFFFF_FFFF);
         end else begin
            e = exp_acc.pop_front();
            chk("acc_addr", mem_addr, e.addr);
            chk("acc_we", 32'(mem_we), 32'(e.we));
            if (e.we) chk("acc_wdata", mem_wdata, e.wdata);
         end
      end
      req_prev = mem_req;
   end

   // Done scoreboard: each done pulse must match the next expected completion
   always @(negedge clk) begin
      dn_t e;
      logic [2:0] who;
      who = {l_done, d_done, i_done};
      if (who !== 3'b000) begin
         if (exp_done.size() == 0) begin
            chk("unexpected_done", 32'(who), 32'd0);
         end else begin
            e = exp_done.pop_front();
            chk("done_who", 32'(who), 32'(e.who));
            if (e.chk) chk("done_rdata", e.who[0] ? i_rdata : d_rdata, e.rdata);
         end
      end
   end

   initial begin
      int hi, nf, nd, cyc;
      bit lseen, fseen, dseen;

      // Reset state
      step();
      step();
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_dones", {29'd0, l_done, d_done, i_done}, 32'd0);
      chk("rst_i_rdata", i_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      chk("rst_terr", 32'(timeout_err), 32'd0);
      reset = 1'b0;

      // 1: lone fetch, ack one cycle after mem_req
      mem[32'h400] = 32'h24020005;
      shadow[32'h400] = 32'h24020005;
      exp_fetch(32'h400);
      i_req = 1'b1; i_addr = 32'h400;
      step();
      chk("t1_mem_req", 32'(mem_req), 32'd1);
      chk("t1_mem_we", 32'(mem_we), 32'd0);
      chk("t1_mem_addr", mem_addr, 32'h400);
      step();
      chk("t1_i_done", 32'(i_done), 32'd1);
      chk("t1_i_rdata", i_rdata, 32'h24020005);
      i_req = 1'b0;
      step();
      chk("t1_done_one_cycle", 32'(i_done), 32'd0);
      chk("t1_mem_req_low", 32'(mem_req), 32'd0);

      // 2: fetch and data held together, 8 requests each, strict F/D alternation
      do_reset();
      for (int k = 0; k < 8; k++) begin
         exp_fetch(32'h500 + 32'(4 * k));
         if (k % 2 == 0) exp_dwrite(dk_addr(k), 32'hCAFEF00D + 32'(k));
         else exp_dread(dk_addr(k));
      end
      nf = 0; nd = 0; cyc = 0;
      i_req = 1'b1; i_addr = 32'h500;
      d_req = 1'b1; d_rd_wr = 1'b0; d_addr = dk_addr(0); d_wdata = 32'hCAFEF00D;
      while ((nf < 8 || nd < 8) && cyc < 300) begin
         step();
         cyc++;
         if (i_done) begin
            nf++;
            if (nf < 8) i_addr = 32'h500 + 32'(4 * nf);
            else i_req = 1'b0;
         end
         if (d_done) begin
            nd++;
            if (nd < 8) begin
               d_rd_wr = (nd % 2 == 1);
               d_addr  = dk_addr(nd);
               d_wdata = 32'hCAFEF00D + 32'(nd);
            end else begin
               d_req = 1'b0;
            end
         end
      end
      chk("t2_fetch_count", 32'(nf), 32'd8);
      chk("t2_data_count", 32'(nd), 32'd8);

      // 3: loader, fetch and data asserted together
      do_reset();
      exp_load(32'h2000, 32'h11112222);
      exp_fetch(32'h600);
      exp_dread(32'h1000);
      l_req = 1'b1; l_addr = 32'h2000; l_wdata = 32'h11112222;
      i_req = 1'b1; i_addr = 32'h600;
      d_req = 1'b1; d_rd_wr = 1'b1; d_addr = 32'h1000;
      lseen = 1'b0; fseen = 1'b0; dseen = 1'b0; cyc = 0;
      while (!(lseen && fseen && dseen) && cyc < 60) begin
         step();
         cyc++;
         if (l_done) begin lseen = 1'b1; l_req = 1'b0; end
         if (i_done) begin fseen = 1'b1; i_req = 1'b0; end
         if (d_done) begin dseen = 1'b1; d_req = 1'b0; end
      end
      chk("t3_all_done", {29'd0, lseen, fseen, dseen}, 32'd7);

      // Stray ack while idle must be ignored
      stray_ack = 1'b1;
      step();
      stray_ack = 1'b0;
      step();
      chk("stray_ack_mem_req", 32'(mem_req), 32'd0);
      chk("stray_ack_dones", {29'd0, l_done, d_done, i_done}, 32'd0);

      // 4: memory never acks, watchdog aborts after 8 cycles
      ack_delay = 0;
      exp_acc.push_back('{1'b0, 32'h700, 32'h0});
      exp_done.push_back('{3'b001, 32'hDEADBEEF, 1'b1});
      i_req = 1'b1; i_addr = 32'h700;
      wait_one("t4", hi);
      chk("t4_req_cycles", 32'(hi), 32'd8);
      chk("t4_mem_req_dropped", 32'(mem_req), 32'd0);
      chk("t4_i_rdata", i_rdata, 32'hDEADBEEF);
      chk("t4_terr", 32'(timeout_err), 32'd1);
      ack_delay = 1;
      exp_fetch(32'h704);
      i_req = 1'b1; i_addr = 32'h704;
      wait_one("t4b", hi);
      step();
      chk("t4_terr_sticky", 32'(timeout_err), 32'd1);

      // 5: reset in the middle of an access discards it
      ack_delay = 0;
      exp_acc.push_back('{1'b1, 32'h3000, 32'h55});
      d_req = 1'b1; d_rd_wr = 1'b0; d_addr = 32'h3000; d_wdata = 32'h55;
      step();
      chk("t5_mem_req", 32'(mem_req), 32'd1);
      step();
      step();
      reset = 1'b1;
      d_req = 1'b0;
      step();
      chk("t5_rst_mem_req", 32'(mem_req), 32'd0);
      chk("t5_rst_dones", {29'd0, l_done, d_done, i_done}, 32'd0);
      chk("t5_rst_terr", 32'(timeout_err), 32'd0);
      reset = 1'b0;
      step();
      step();
      chk("t5_post_dones", {29'd0, l_done, d_done, i_done}, 32'd0);
      ack_delay = 1;
      exp_dread(32'h1000);
      d_req = 1'b1; d_rd_wr = 1'b1; d_addr = 32'h1000;
      wait_one("t5b", hi);
      chk("t5_fresh_rdata", d_rdata, 32'hCAFEF00D);

      // 6: ack arrives on the cycle the watchdog expires
      ack_delay = 8;
      exp_fetch(32'h800);
      i_req = 1'b1; i_addr = 32'h800;
      wait_one("t6", hi);
      chk("t6_req_cycles", 32'(hi), 32'd8);
      chk("t6_i_rdata", i_rdata, dflt(32'h800));
      chk("t6_terr", 32'(timeout_err), 32'd0);
      step();
      step();

      chk("acc_queue_empty", 32'(exp_acc.size()), 32'd0);
      chk("done_queue_empty", 32'(exp_done.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
